mult_control: RTL and testbench

Sequencing controller for the WIDTH-bit add-shift multiplier datapath: the X sign flip-flop, accumulator register A and multiplier register B. It turns the operator's Run and ClearA_LoadB inputs into the single-cycle Clear_XA, Clr_Ld, Add, Sub and Shift strobes for one signed multiplication. One Run assertion executes the full WIDTH-iteration algorithm, with a subtract on the final iteration. The block then holds in a done state until Run is released.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_control_if.sv | 22 ++
 rtl/mult_control_iter_counter.sv | 23 ++
 rtl/mult_control.sv | 95 +++++++++
 tb/tb_mult_control.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier controller and datapath.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLRXA,
    ADD,
    SHIFT,
    HOLD
  } mult_state_t;

endpackage

// File: rtl/mult_control_if.sv
// Operator inputs, multiplier LSB and datapath strobes between the controller and its environment.
interface mult_control_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld;
  logic Clear_XA;
  logic Add;
  logic Sub;
  logic Shift;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_Ld, Clear_XA, Add, Sub, Shift, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_Ld, Clear_XA, Add, Sub, Shift, Done
  );
endinterface

// File: rtl/mult_control_iter_counter.sv
// Iteration counter: synchronous clear, increment enable, terminal-count flag at WIDTH-1.
module iter_counter
  import mult_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge Clk) begin
    if (Reset || clr) cnt <= '0;
    else if (inc)     cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Signed add-shift multiply sequencer; MULT_CTRL_ZERO_SKIP_EN folds the shift into ADD when M=0.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic           Clk,
  input logic           Reset,
  mult_control_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_t   state, next;
  logic          cnt_clr, cnt_inc, last;
  logic [CW-1:0] cnt;
  logic          clr_ld, clear_xa, add, sub, shift, done;

  iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next     = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    clr_ld   = 1'b0;
    clear_xa = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        // Run wins over a simultaneous load request
        clr_ld = bus.ClearA_LoadB & ~bus.Run;
        if (bus.Run) begin
          next    = CLRXA;
          cnt_clr = 1'b1;
        end
      end
      CLRXA: begin
        clear_xa = 1'b1;
        next     = ADD;
      end
      ADD: begin
        if (bus.M) begin
          // Top multiplier bit carries negative weight in two's complement
          add  = ~last;
          sub  = last;
          next = SHIFT;
        end else begin
`ifdef MULT_CTRL_ZERO_SKIP_EN
          shift = 1'b1;
          if (last) next = HOLD;
          else      cnt_inc = 1'b1;
`else
          next = SHIFT;
`endif
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) next = HOLD;
        else begin
          cnt_inc = 1'b1;
          next    = ADD;
        end
      end
      HOLD: begin
        done = 1'b1;
        if (!bus.Run) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign bus.Clr_Ld   = clr_ld;
  assign bus.Clear_XA = clear_xa;
  assign bus.Add      = add;
  assign bus.Sub      = sub;
  assign bus.Shift    = shift;
  assign bus.Done     = done;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: per-cycle strobe sequences compared against a bit-by-bit schedule model.
module tb_mult_control;
  import mult_pkg::*;

  localparam int W = WIDTH_DEF;
`ifdef MULT_CTRL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // strobe vector layout: {Clr_Ld, Clear_XA, Add, Sub, Shift, Done}
  localparam logic [5:0] V_NONE = 6'b000000;
  localparam logic [5:0] V_CLD  = 6'b100000;
  localparam logic [5:0] V_CXA  = 6'b010000;
  localparam logic [5:0] V_ADD  = 6'b001000;
  localparam logic [5:0] V_SUB  = 6'b000100;
  localparam logic [5:0] V_SH   = 6'b000010;
  localparam logic [5:0] V_DONE = 6'b000001;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mult_control_if bus();

  mult_control #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  wire [5:0] ov = {bus.Clr_Ld, bus.Clear_XA, bus.Add, bus.Sub, bus.Shift, bus.Done};

  int nvec = 0;
  int nerr = 0;
  logic [5:0] exp_q[$];

  // Expected strobes for each cycle after Run is sampled, through the first HOLD cycle
  task automatic build_exp(input logic [W-1:0] b);
    exp_q.delete();
    exp_q.push_back(V_CXA);
    for (int i = 0; i < W; i++) begin
      if (b[i])      exp_q.push_back((i == W - 1) ? V_SUB : V_ADD);
      else if (!SKIP) exp_q.push_back(V_NONE);
      exp_q.push_back(V_SH);
    end
    exp_q.push_back(V_DONE);
  endtask

  // Called at a negedge; returns at a negedge with the FSM back in IDLE
  task automatic run_mult(input logic [W-1:0] b, input int hold, input string tag);
    int sc;
    int nsh;
    sc  = 0;
    nsh = 0;
    build_exp(b);
    bus.Run = 1'b1;
    bus.ClearA_LoadB = 1'b0;
    bus.M = b[0];
    foreach (exp_q[k]) begin
      @(negedge Clk);
      nvec++;
      if (ov !== exp_q[k]) begin
        nerr++;
        $display("FAIL %s seq b=%h cyc %0d: got %b want %b", tag, b, k + 1, ov, exp_q[k]);
      end
      if (ov[1] === 1'b1) begin
        nsh++;
        sc++;
      end
      bus.M = (sc < W) ? b[sc] : 1'($urandom);
      bus.ClearA_LoadB = 1'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      nvec++;
      if (ov !== V_DONE) begin
        nerr++;
        $display("FAIL %s hold cyc %0d: got %b want %b", tag, h, ov, V_DONE);
      end
      if (ov[1] === 1'b1) nsh++;
      bus.ClearA_LoadB = 1'($urandom);
    end
    nvec++;
    if (nsh != W) begin
      nerr++;
      $display("FAIL %s shift_count: got %0d want %0d", tag, nsh, W);
    end
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    nvec++;
    if (ov !== V_NONE) begin
      nerr++;
      $display("FAIL %s release_idle: got %b want %b", tag, ov, V_NONE);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.M = 1'b0;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      bus.ClearA_LoadB = 1'(i);
      #1;
      nvec++;
      if (ov !== {bus.ClearA_LoadB, 5'b0}) begin
        nerr++;
        $display("FAIL reset_outputs %0d: got %b want %b", i, ov, {bus.ClearA_LoadB, 5'b0});
      end
      @(negedge Clk);
    end
    Reset = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_idle_load();
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    #1;
    nvec++;
    if (ov !== V_CLD) begin
      nerr++;
      $display("FAIL idle_load: got %b want %b", ov, V_CLD);
    end
    bus.Run = 1'b1;
    #1;
    nvec++;
    if (ov !== V_NONE) begin
      nerr++;
      $display("FAIL run_priority: got %b want %b", ov, V_NONE);
    end
    @(negedge Clk);
    nvec++;
    if (ov !== V_CXA) begin
      nerr++;
      $display("FAIL run_priority_next: got %b want %b", ov, V_CXA);
    end
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    nvec++;
    if (ov !== V_NONE) begin
      nerr++;
      $display("FAIL idle_abort: got %b want %b", ov, V_NONE);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] b;
    int sc;
    b  = W'($urandom);
    sc = 0;
    build_exp(b);
    bus.Run = 1'b1;
    bus.ClearA_LoadB = 1'b0;
    bus.M = b[0];
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      nvec++;
      if (ov !== exp_q[c-1]) begin
        nerr++;
        $display("FAIL midrst_pre cyc %0d: got %b want %b", c, ov, exp_q[c-1]);
      end
      if (ov[1] === 1'b1) sc++;
      bus.M = b[sc];
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.Run = 1'b0;
    for (int c = 6; c < 16; c++) begin
      bus.M = 1'($urandom);
      nvec++;
      if (ov !== V_NONE) begin
        nerr++;
        $display("FAIL midrst_post cyc %0d: got %b want %b", c, ov, V_NONE);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_directed();
    run_mult(W'(8'h07), 0, "b07");
    run_mult(W'(8'h80), 2, "b80");
    run_mult(W'(8'h00), 1, "b00");
    run_mult(W'(8'hFF), 0, "bFF");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b;
    b = W'($urandom);
    run_mult(b, 30, "rerun1");
    run_mult(b, 30, "rerun2");
  endtask

  task automatic test_random();
    repeat (8) run_mult(W'($urandom), $urandom_range(0, 5), "rand");
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_directed();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
